// File: rtl/reg_bus_arb_pkg.sv
// Shared types and helpers for the register-bus arbiter.
// Optional watchdog: REG_BUS_ARB_TIMEOUT_EN.
package reg_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request
// at or above rr_ptr, wrapping modulo N.
module rr_pick
  import reg_bus_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int            c;
  logic [IW-1:0] cand;

  // Walk offsets high to low so the closest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    cand  = '0;
    for (int off = N - 1; off >= 0; off--) begin
      c = int'(rr_ptr) + off;
      if (c >= N) c = c - N;
      cand = IW'(c);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register bus among
// NUM_REQ bridges. Watchdog under REG_BUS_ARB_TIMEOUT_EN.
module reg_bus_arbiter
  import reg_bus_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              m_req,
  input  logic [NUM_REQ-1:0]              m_is_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   m_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   m_wr_data,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] m_wr_biten,
  output logic [NUM_REQ-1:0]              m_ready,
  output logic [DATA_WIDTH-1:0]           m_rd_data,
  output logic                            m_err,
  output logic                            o_bus_req,
  output logic                            o_bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0]           o_bus_addr,
  output logic [DATA_WIDTH-1:0]           o_bus_wr_data,
  output logic [DATA_WIDTH/8-1:0]         o_bus_wr_biten,
  input  logic                            bus_req_stall_wr,
  input  logic                            bus_req_stall_rd,
  input  logic                            bus_ready,
  input  logic [DATA_WIDTH-1:0]           bus_rd_data,
  input  logic                            bus_err,
  output logic [idx_w(NUM_REQ)-1:0]       grant_idx
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int BW = DATA_WIDTH / 8;

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("reg_bus_arbiter: bad parameter");
  end

  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdat_a [NUM_REQ];
  logic [BW-1:0]         bten_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] =
      m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdat_a[i] =
      m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign bten_a[i] =
      m_wr_biten[i*BW +: BW];
  end

  arb_state_t            state_q;
  arb_state_t            state_d;
  logic [IW-1:0]         rr_ptr;
  logic                  pick_valid;
  logic [IW-1:0]         pick_idx;
  logic                  cap_is_wr;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [BW-1:0]         cap_biten;
  logic                  stall;
  logic                  issue_go;
  logic                  bus_done;
  logic                  to_hit;
  logic                  done;
  logic [IW-1:0]         rr_next;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req    (m_req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  assign stall = cap_is_wr ? bus_req_stall_wr
                           : bus_req_stall_rd;

  // rst also masks outputs so an abandoned
  // transaction never leaks a strobe or a pulse.
  assign issue_go = !rst && (state_q == ISSUE)
                    && !stall;

  assign bus_done = bus_ready &&
                    (issue_go ||
                     (!rst && state_q == WAIT));

`ifdef REG_BUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;

  // Held at zero in IDLE so it reads 0 on ISSUE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state_q == IDLE) begin
      to_cnt <= '0;
    end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign to_hit = !rst && (state_q != IDLE) &&
                  (to_cnt == TW'(TIMEOUT_CYCLES)) &&
                  !bus_done;
`else
  assign to_hit = 1'b0;
`endif

  assign done = bus_done || to_hit;

  assign rr_next =
    (grant_idx == IW'(NUM_REQ - 1)) ? '0
                                    : grant_idx + IW'(1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) state_d = ISSUE;
      end
      ISSUE: begin
        if (!stall)
          state_d = bus_ready ? IDLE : WAIT;
      end
      WAIT: begin
        if (bus_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (to_hit) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      cap_is_wr <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_biten <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_valid) begin
        grant_idx <= pick_idx;
        cap_is_wr <= m_is_wr[pick_idx];
        cap_addr  <= addr_a[pick_idx];
        cap_wdata <= wdat_a[pick_idx];
        cap_biten <= bten_a[pick_idx];
      end
      if (done) rr_ptr <= rr_next;
    end
  end

  always_comb begin
    o_bus_req       = issue_go;
    o_bus_req_is_wr = 1'b0;
    o_bus_addr      = '0;
    o_bus_wr_data   = '0;
    o_bus_wr_biten  = '0;
    if (issue_go) begin
      o_bus_req_is_wr = cap_is_wr;
      o_bus_addr      = cap_addr;
      o_bus_wr_data   = cap_wdata;
      o_bus_wr_biten  = cap_biten;
    end
  end

  always_comb begin
    m_ready   = '0;
    m_rd_data = '0;
    m_err     = 1'b0;
    if (done) m_ready[grant_idx] = 1'b1;
    if (bus_done) begin
      m_rd_data = bus_rd_data;
      m_err     = bus_err;
    end else if (to_hit) begin
      m_err = 1'b1;
    end
  end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares the single register-block CPU bus (o_bus_req/bus_ready handshake) between NUM_REQ upstream bus bridges, e.g. the APB4 slave plus a debug/JTAG host.
- Round-robin grant with one outstanding transaction at a time. Honours downstream write/read stall signals and routes each response back only to the granted requester.
- Sits between the protocol bridges and the generated register block.

Parameters:
- NUM_REQ, 2, number of upstream requesters (2..8)
- ADDR_WIDTH, 3, register-bus address width
- DATA_WIDTH, 32, register-bus data width; biten width = DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, watchdog limit; used only with REG_BUS_ARB_TIMEOUT_EN

Ports:
- clk  in  1  bus clock
- rst  in  1  synchronous, active-high reset
- m_req  in  NUM_REQ  per-requester request level; held until that requester's m_ready
- m_is_wr  in  NUM_REQ  per-requester write flag
- m_addr  in  NUM_REQ*ADDR_WIDTH  flattened; slice i is requester i
- m_wr_data  in  NUM_REQ*DATA_WIDTH  flattened
- m_wr_biten  in  NUM_REQ*DATA_WIDTH/8  flattened byte enables
- m_ready  out  NUM_REQ  one-cycle completion pulse to the granted requester
- m_rd_data  out  DATA_WIDTH  response data, valid with any m_ready bit
- m_err  out  1  response error, valid with any m_ready bit
- o_bus_req  out  1  downstream request strobe
- o_bus_req_is_wr  out  1  downstream write flag
- o_bus_addr  out  ADDR_WIDTH  downstream address
- o_bus_wr_data  out  DATA_WIDTH  downstream write data
- o_bus_wr_biten  out  DATA_WIDTH/8  downstream byte enables
- bus_req_stall_wr  in  1  downstream cannot accept a write this cycle
- bus_req_stall_rd  in  1  downstream cannot accept a read this cycle
- bus_ready  in  1  downstream completion strobe
- bus_rd_data  in  DATA_WIDTH  downstream read data
- bus_err  in  1  downstream error
- grant_idx  out  $clog2(NUM_REQ)  currently/last granted index (debug)

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, rr_ptr=0, grant_idx=0, captured command=0.
  - All outputs 0: o_bus_*, m_ready, m_rd_data, m_err.
- A stray bus_ready while in IDLE is ignored; no m_ready is generated.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any m_req is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - On that edge, register grant_idx and capture the winner's is_wr/addr/wr_data/biten, then go to ISSUE.
  - If no m_req is set, stay in IDLE.
- ISSUE:
  - stall = captured is_wr ? bus_req_stall_wr : bus_req_stall_rd.
  - If stall=1: o_bus_req=0; stay in ISSUE.
  - If stall=0: o_bus_req=1 for exactly this cycle, o_bus_* driven from the captured command, and the FSM goes to WAIT.
  - If bus_ready is also 1 in this same cycle, complete immediately (zero-latency target) and go to IDLE instead of WAIT.
- WAIT: o_bus_req=0. When bus_ready=1, complete and go to IDLE.
- Completion:
  - Combinational, in the bus_ready cycle: m_ready[grant_idx]=1, m_rd_data=bus_rd_data, m_err=bus_err.
  - At the edge: rr_ptr = (grant_idx+1) mod NUM_REQ.
- o_bus_* are 0 whenever o_bus_req=0. m_rd_data and m_err are 0 whenever no m_ready bit is set.
- Throughput: at most one transaction per 2 cycles; minimum latency m_req -> m_ready is 2 cycles.
- Requester lock: the command is captured once, so later changes to the granted requester's m_* inputs have no effect. If m_req drops mid-transaction, the transaction still completes and m_ready still pulses.
- Fairness: a requester that holds m_req is granted within NUM_REQ transactions.
- rst mid-transaction: abandon immediately. No m_ready is issued; a late bus_ready is ignored.

Optional Feature:
- Macro: REG_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - When it reaches TIMEOUT_CYCLES without bus_ready, the arbiter forces completion: m_ready[grant_idx]=1, m_err=1, m_rd_data=0, then goes to IDLE.
  - A later stray bus_ready is ignored.
  - bus_ready in the same cycle as the timeout takes precedence: normal completion.
- Undefined: no counter logic; the arbiter waits indefinitely.

Decomposition:
- Package reg_bus_arb_pkg: state enum arb_state_t {IDLE, ISSUE, WAIT}; function for the index width, $clog2 with a minimum of 1.
- Sub-module rr_pick: combinational round-robin priority pick. Inputs: req vector, rr_ptr. Outputs: valid, index.

Test Plan:
- Single read: m_req=2'b01, m_addr[0]=3'h4, bus_ready one cycle after o_bus_req with bus_rd_data=32'hDEADBEEF -> o_bus_req pulses one cycle with addr 4 and is_wr=0; m_ready=2'b01, m_rd_data=DEADBEEF, m_err=0.
- Contention: m_req=2'b11 held for 4 transactions from reset -> grant order 0,1,0,1; each m_ready is one-hot to the matching requester.
- Stall: write with bus_req_stall_wr=1 for 3 cycles -> o_bus_req stays 0 for those 3 cycles, then pulses once with wr_data/biten intact. bus_req_stall_rd=1 does not block the write.
- Zero-latency target: bus_ready=1 in the o_bus_req cycle -> m_ready in that same cycle, and the next grant can be taken on the following edge.
- Reset mid-WAIT: rst=1 for 1 cycle, then bus_ready=1 -> no m_ready, o_bus_req=0, next grant starts from requester 0.
- Timeout (REG_BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): bus_ready never asserted -> m_ready pulses with m_err=1 and m_rd_data=0 once the counter reaches 8 (about 9 cycles after entering ISSUE), and the arbiter returns to IDLE.
